// File: rtl/cp0_exc_seq_pkg.sv
// Shared CPU definitions: CP0 exception codes, handler entry and sequencer types.
package cpu_defs;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
    localparam int unsigned CNT_W_DEF      = 16;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1,
        ST_TAKE = 2'd2,
        ST_ERET = 2'd3
    } seq_state_t;

    // Victim record handed to CP0 when a trap commits
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  code;
        logic        nbd;
    } exc_rec_t;

endpackage

// File: rtl/cp0_exc_seq_if.sv
// M-stage / CP0 / PC-redirect signals seen by the exception sequencer.
interface cp0_exc_seq_if #(
    parameter int unsigned CNT_W = 16
);
    logic              m_valid;
    logic [31:0]       m_pc;
    logic              m_bd;
    logic [4:0]        m_exc_code;
    logic              m_eret;
    logic              int_req;
    logic              md_busy;
    logic [29:0]       epc;

    logic              stall;
    logic              flush;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic              cp0_exc_valid;
    logic [31:0]       cp0_pc;
    logic [4:0]        cp0_exc_code;
    logic              cp0_nbd;
    logic              cp0_exlclr;
    logic [CNT_W-1:0]  exc_count;

    modport master (
        output m_valid, m_pc, m_bd, m_exc_code, m_eret, int_req, md_busy, epc,
        input  stall, flush, redirect, redirect_pc, cp0_exc_valid, cp0_pc,
               cp0_exc_code, cp0_nbd, cp0_exlclr, exc_count
    );

    modport slave (
        input  m_valid, m_pc, m_bd, m_exc_code, m_eret, int_req, md_busy, epc,
        output stall, flush, redirect, redirect_pc, cp0_exc_valid, cp0_pc,
               cp0_exc_code, cp0_nbd, cp0_exlclr, exc_count
    );
endinterface

// File: rtl/cp0_exc_seq.sv
// Exception/interrupt sequencer: freezes the pipe for one decision cycle, then
// commits a trap or eret to CP0 and redirects fetch.
module cp0_exc_seq
    import cpu_defs::*;
#(
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic           clk,
    input  logic           reset,
    cp0_exc_seq_if.slave   bus
);

    seq_state_t        state_q, state_d;
    exc_rec_t          rec_q, rec_d;
    logic              rec_ld;
    logic [29:0]       epc_q;
    logic              epc_ld;
    logic [CNT_W-1:0]  count_q;
    logic              stall_c;
    logic              in_take, in_eret;

    // Priority decode: interrupt > synchronous exception > eret
    always_comb begin
        state_d = state_q;
        stall_c = 1'b0;
        rec_ld  = 1'b0;
        epc_ld  = 1'b0;
        rec_d   = '{pc: bus.m_pc, code: bus.m_exc_code, nbd: ~bus.m_bd};
        unique case (state_q)
            ST_RUN: begin
                if (bus.m_valid) begin
                    if (bus.int_req) begin
                        stall_c = 1'b1;
                        if (bus.md_busy) begin
                            state_d = ST_HOLD;
                        end else begin
                            rec_ld     = 1'b1;
                            rec_d.code = EXC_INT;
                            state_d    = ST_TAKE;
                        end
                    end else if (bus.m_exc_code != 5'd0) begin
                        stall_c = 1'b1;
                        rec_ld  = 1'b1;
                        state_d = ST_TAKE;
                    end else if (bus.m_eret) begin
                        stall_c = 1'b1;
                        epc_ld  = 1'b1;
                        state_d = ST_ERET;
                    end
                end
            end
            ST_HOLD: begin
                // Synchronous faults are never deferred behind mult/div
                stall_c = 1'b1;
                if (bus.m_exc_code != 5'd0) begin
                    rec_ld  = 1'b1;
                    state_d = ST_TAKE;
                end else if (!bus.int_req) begin
                    state_d = ST_RUN;
                end else if (!bus.md_busy) begin
                    rec_ld     = 1'b1;
                    rec_d.code = EXC_INT;
                    state_d    = ST_TAKE;
                end
            end
            ST_TAKE: state_d = ST_RUN;
            ST_ERET: state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            rec_q   <= '0;
            epc_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (rec_ld) rec_q <= rec_d;
            if (epc_ld) epc_q <= bus.epc;
            if (state_q == ST_TAKE) count_q <= count_q + CNT_W'(1);
        end
    end

    assign in_take = (state_q == ST_TAKE);
    assign in_eret = (state_q == ST_ERET);

    // Commit-cycle outputs decode straight from the registered state
    assign bus.stall         = stall_c & ~reset;
    assign bus.flush         = in_take | in_eret;
    assign bus.redirect      = in_take | in_eret;
    assign bus.redirect_pc   = in_take ? HANDLER_PC :
                               in_eret ? {epc_q, 2'b00} : 32'd0;
    assign bus.cp0_exc_valid = in_take;
    assign bus.cp0_exlclr    = in_eret;
    assign bus.cp0_pc        = rec_q.pc;
    assign bus.cp0_exc_code  = rec_q.code;
    assign bus.cp0_nbd       = rec_q.nbd;
    assign bus.exc_count     = count_q;

endmodule

// File: tb/tb_cp0_exc_seq.sv
// Bench for cp0_exc_seq: directed vector table, counter wrap, randomized run vs. model.
module tb_cp0_exc_seq;
    import cpu_defs::*;

    localparam int unsigned CW  = 8;
    localparam logic [31:0] HPC = 32'h0000_4180;

    logic clk = 1'b0;
    logic reset;

    cp0_exc_seq_if #(.CNT_W(CW)) bus ();
    cp0_exc_seq #(.HANDLER_PC(HPC), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        stall;
        logic        flush;
        logic        redirect;
        logic [31:0] rpc;
        logic        xv;
        logic [31:0] cpc;
        logic [4:0]  ccode;
        logic        nbd;
        logic        exl;
        logic [CW-1:0] cnt;
    } exp_t;

    typedef struct packed {
        logic        rst;
        logic        v;
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  code;
        logic        er;
        logic        irq;
        logic        busy;
        logic [29:0] epc;
        exp_t        e;
    } vec_t;

    // Reference model: what the next cycle owes the pipeline
    int          pend;      // 0 nothing, 1 trap commit, 2 eret commit
    bit          waiting;   // interrupt parked behind mult/div
    logic [31:0] m_cpc;
    logic [4:0]  m_ccode;
    logic        m_nbd;
    logic [29:0] m_epc;
    int unsigned m_cnt;

    function automatic vec_t mkv(input logic rst, v, input logic [31:0] pc, input logic bd,
                                 input logic [4:0] code, input logic er, irq, busy,
                                 input logic [29:0] epc,
                                 input logic st, fl, input logic [31:0] rpc, input logic xv,
                                 input logic [31:0] cpc, input logic [4:0] cc, input logic nbd,
                                 input logic exl, input int unsigned cnt);
        vec_t r;
        r.rst = rst; r.v = v; r.pc = pc; r.bd = bd; r.code = code;
        r.er = er; r.irq = irq; r.busy = busy; r.epc = epc;
        r.e.stall = st; r.e.flush = fl; r.e.redirect = fl; r.e.rpc = rpc; r.e.xv = xv;
        r.e.cpc = cpc; r.e.ccode = cc; r.e.nbd = nbd; r.e.exl = exl; r.e.cnt = CW'(cnt);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".stall"},        32'(bus.stall),         32'(e.stall));
        chk({tag, ".flush"},        32'(bus.flush),         32'(e.flush));
        chk({tag, ".redirect"},     32'(bus.redirect),      32'(e.redirect));
        chk({tag, ".redirect_pc"},  bus.redirect_pc,        e.rpc);
        chk({tag, ".cp0_exc_valid"},32'(bus.cp0_exc_valid), 32'(e.xv));
        chk({tag, ".cp0_pc"},       bus.cp0_pc,             e.cpc);
        chk({tag, ".cp0_exc_code"}, 32'(bus.cp0_exc_code),  32'(e.ccode));
        chk({tag, ".cp0_nbd"},      32'(bus.cp0_nbd),       32'(e.nbd));
        chk({tag, ".cp0_exlclr"},   32'(bus.cp0_exlclr),    32'(e.exl));
        chk({tag, ".exc_count"},    32'(bus.exc_count),     32'(e.cnt));
    endtask

    function automatic exp_t model_exp();
        exp_t e;
        e       = '0;
        e.cpc   = m_cpc;
        e.ccode = m_ccode;
        e.nbd   = m_nbd;
        e.cnt   = CW'(m_cnt);
        if (pend == 1) begin
            e.flush = 1'b1; e.redirect = 1'b1; e.rpc = HPC; e.xv = 1'b1;
        end else if (pend == 2) begin
            e.flush = 1'b1; e.redirect = 1'b1; e.rpc = {m_epc, 2'b00}; e.exl = 1'b1;
        end else if (waiting) begin
            e.stall = 1'b1;
        end else if (bus.m_valid && (bus.int_req || bus.m_exc_code != 5'd0 || bus.m_eret)) begin
            e.stall = 1'b1;
        end
        if (reset) e.stall = 1'b0;
        return e;
    endfunction

    task automatic model_clear();
        pend = 0; waiting = 0; m_cpc = '0; m_ccode = '0; m_nbd = 1'b0; m_epc = '0; m_cnt = 0;
    endtask

    task automatic capture(input logic [4:0] code);
        m_cpc = bus.m_pc; m_ccode = code; m_nbd = ~bus.m_bd; pend = 1; waiting = 0;
    endtask

    task automatic model_step();
        if (reset) begin
            model_clear();
        end else if (pend != 0) begin
            if (pend == 1) m_cnt = (m_cnt + 1) % (1 << CW);
            pend = 0;
        end else if (waiting) begin
            if (bus.m_exc_code != 5'd0) capture(bus.m_exc_code);
            else if (!bus.int_req)      waiting = 0;
            else if (!bus.md_busy)      capture(5'd0);
        end else if (bus.m_valid) begin
            if (bus.int_req) begin
                if (bus.md_busy) waiting = 1;
                else             capture(5'd0);
            end else if (bus.m_exc_code != 5'd0) begin
                capture(bus.m_exc_code);
            end else if (bus.m_eret) begin
                m_epc = bus.epc; pend = 2;
            end
        end
    endtask

    // Check the current cycle at the falling edge, then advance the model
    task automatic run_cycle(input string tag, input bit use_tab, input exp_t te);
        exp_t me;
        @(negedge clk);
        me = model_exp();
        chk_all(tag, use_tab ? te : me);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, v, input logic [31:0] pc, input logic bd,
                         input logic [4:0] code, input logic er, irq, busy,
                         input logic [29:0] epc);
        reset = rst; bus.m_valid = v; bus.m_pc = pc; bus.m_bd = bd; bus.m_exc_code = code;
        bus.m_eret = er; bus.int_req = irq; bus.md_busy = busy; bus.epc = epc;
    endtask

    vec_t tab[$];
    exp_t none;
    logic [4:0] codes [4];

    initial begin
        none = '0;
        codes[0] = EXC_ADEL; codes[1] = EXC_ADES; codes[2] = EXC_RI; codes[3] = EXC_OV;

        // rst v  pc         bd code er irq busy epc    | st fl rpc        xv cpc        cc  nbd exl cnt
        tab.push_back(mkv(0,0,32'h0,   0,0, 0,0,0,30'h0,   0,0,32'h0,   0,32'h0,   0, 0,0,0));
        tab.push_back(mkv(0,1,32'h3008,0,10,0,0,0,30'h0,   1,0,32'h0,   0,32'h0,   0, 0,0,0));
        tab.push_back(mkv(0,0,32'h0,   0,0, 0,0,0,30'h0,   0,1,32'h4180,1,32'h3008,10,1,0,0));
        tab.push_back(mkv(0,0,32'h0,   0,0, 0,0,0,30'h0,   0,0,32'h0,   0,32'h3008,10,1,0,1));
        for (int i = 0; i < 3; i++)
            tab.push_back(mkv(0,1,32'h3010,1,0,0,1,1,30'h0, 1,0,32'h0,0,32'h3008,10,1,0,1));
        tab.push_back(mkv(0,1,32'h3010,1,0, 0,1,0,30'h0,   1,0,32'h0,   0,32'h3008,10,1,0,1));
        tab.push_back(mkv(0,0,32'h0,   0,0, 0,0,0,30'h0,   0,1,32'h4180,1,32'h3010,0, 0,0,1));
        tab.push_back(mkv(0,0,32'h0,   0,0, 0,0,0,30'h0,   0,0,32'h0,   0,32'h3010,0, 0,0,2));
        tab.push_back(mkv(0,1,32'h3020,0,0, 1,0,0,30'hC05, 1,0,32'h0,   0,32'h3010,0, 0,0,2));
        tab.push_back(mkv(0,0,32'h0,   0,0, 0,0,0,30'h0,   0,1,32'h3014,0,32'h3010,0, 0,1,2));
        tab.push_back(mkv(0,0,32'h0,   0,0, 0,0,0,30'h0,   0,0,32'h0,   0,32'h3010,0, 0,0,2));
        tab.push_back(mkv(0,1,32'h3024,0,0, 1,1,0,30'hC05, 1,0,32'h0,   0,32'h3010,0, 0,0,2));
        tab.push_back(mkv(0,0,32'h0,   0,0, 0,0,0,30'h0,   0,1,32'h4180,1,32'h3024,0, 1,0,2));
        tab.push_back(mkv(0,0,32'h0,   0,0, 0,0,0,30'h0,   0,0,32'h0,   0,32'h3024,0, 1,0,3));
        tab.push_back(mkv(0,0,32'h0,   0,0, 0,1,0,30'h0,   0,0,32'h0,   0,32'h3024,0, 1,0,3));
        tab.push_back(mkv(0,1,32'h3030,0,0, 0,1,1,30'h0,   1,0,32'h0,   0,32'h3024,0, 1,0,3));
        tab.push_back(mkv(0,1,32'h3030,0,0, 0,0,1,30'h0,   1,0,32'h0,   0,32'h3024,0, 1,0,3));
        tab.push_back(mkv(0,0,32'h0,   0,0, 0,0,0,30'h0,   0,0,32'h0,   0,32'h3024,0, 1,0,3));
        tab.push_back(mkv(0,1,32'h3040,0,0, 0,1,1,30'h0,   1,0,32'h0,   0,32'h3024,0, 1,0,3));
        tab.push_back(mkv(0,1,32'h3040,0,12,0,1,1,30'h0,   1,0,32'h0,   0,32'h3024,0, 1,0,3));
        tab.push_back(mkv(0,0,32'h0,   0,0, 0,0,0,30'h0,   0,1,32'h4180,1,32'h3040,12,1,0,3));
        tab.push_back(mkv(0,0,32'h0,   0,0, 0,0,0,30'h0,   0,0,32'h0,   0,32'h3040,12,1,0,4));
        tab.push_back(mkv(1,1,32'h3050,0,4, 0,0,0,30'h0,   0,0,32'h0,   0,32'h3040,12,1,0,4));
        tab.push_back(mkv(0,0,32'h0,   0,0, 0,0,0,30'h0,   0,0,32'h0,   0,32'h0,   0, 0,0,0));
        tab.push_back(mkv(0,0,32'h0,   0,5, 0,0,0,30'h0,   0,0,32'h0,   0,32'h0,   0, 0,0,0));
        tab.push_back(mkv(0,0,32'h0,   0,0, 0,0,0,30'h0,   0,0,32'h0,   0,32'h0,   0, 0,0,0));

        drive(1, 0, 32'h0, 0, 5'd0, 0, 0, 0, 30'h0);
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        foreach (tab[i]) begin
            drive(tab[i].rst, tab[i].v, tab[i].pc, tab[i].bd, tab[i].code,
                  tab[i].er, tab[i].irq, tab[i].busy, tab[i].epc);
            run_cycle($sformatf("vec%0d", i), 1'b1, tab[i].e);
        end

        // Counter wrap: a faulting instruction held in M traps every two cycles
        drive(0, 1, 32'h3060, 0, EXC_ADEL, 0, 0, 0, 30'h0);
        for (int i = 0; i < 2 * ((1 << CW) - 1); i++) run_cycle("wrap_fill", 1'b0, none);
        chk("wrap_full", 32'(bus.exc_count), 32'((1 << CW) - 1));
        drive(0, 1, 32'h3064, 0, EXC_OV, 0, 0, 0, 30'h0);
        run_cycle("wrap_det", 1'b0, none);
        drive(0, 0, 32'h0, 0, 5'd0, 0, 0, 0, 30'h0);
        run_cycle("wrap_take", 1'b0, none);
        chk("wrap_zero", 32'(bus.exc_count), 32'd0);

        // Randomized traffic; M stays frozen while an interrupt is parked
        for (int i = 0; i < 4000; i++) begin
            if (waiting) begin
                reset       = ($urandom_range(99) == 0);
                bus.int_req = ($urandom_range(9) < 8);
                bus.md_busy = ($urandom_range(9) < 7);
            end else begin
                drive($urandom_range(99) == 0,
                      $urandom_range(3) != 0,
                      $urandom() & 32'hFFFF_FFFC,
                      1'($urandom_range(1)),
                      ($urandom_range(4) == 0) ? codes[$urandom_range(3)] : 5'd0,
                      $urandom_range(6) == 0,
                      $urandom_range(4) == 0,
                      $urandom_range(4) < 2,
                      30'($urandom()));
            end
            run_cycle("rand", 1'b0, none);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
